// File: rtl/l2_evict_buffer_pkg.sv
// Shared types for the L2 write-back eviction buffer.
// Line/tag widths and the buffer FSM state encoding.
package lc3b_types;
  localparam int C_ADDR_W = 16;
  localparam int C_LINE_W = 128;

  typedef logic [C_ADDR_W-1:0] lc3b_word;
  typedef logic [C_LINE_W-1:0] lc3b_c_line;
  typedef logic [C_ADDR_W-5:0] lc3b_line_tag;

  typedef enum logic [1:0] {
    IDLE,
    RD_MEM,
    DRAIN
  } lc3b_evict_state;
endpackage

// File: rtl/l2_evict_buffer_array.sv
// Circular line store for the eviction buffer.
// Push at tail, pop at head, coalesce into the matching entry.
module l2_evict_array #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = lc3b_types::C_ADDR_W,
  parameter int LINE_W = lc3b_types::C_LINE_W,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-5:0] tag,
  input  logic [LINE_W-1:0] line,
  input  logic              push,
  input  logic              pop,
  input  logic              coal,
  output logic [DEPTH-1:0]  match,
  output logic [LINE_W-1:0] match_line,
  output logic [ADDR_W-5:0] head_tag,
  output logic [LINE_W-1:0] head_line,
  output logic [PW-1:0]     head_idx,
  output logic [PW:0]       count,
  output logic              full
);
  localparam logic [PW:0] CNT_MAX = (PW+1)'(DEPTH);

  logic              valid  [DEPTH];
  logic [ADDR_W-5:0] tag_q  [DEPTH];
  logic [LINE_W-1:0] line_q [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;

  assign full      = (count == CNT_MAX);
  assign head_idx  = head;
  assign head_tag  = tag_q[head];
  assign head_line = line_q[head];

  // Tag lookup: one-hot hit vector and the hit entry's line.
  always_comb begin
    match      = '0;
    match_line = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && (tag_q[i] == tag);
      if (match[i]) match_line = line_q[i];
    end
  end

  // Valid bits, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) valid[i] <= 1'b0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload; meaningful only while valid, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[tail]  <= tag;
      line_q[tail] <= line;
    end
    if (coal) begin
      for (int i = 0; i < DEPTH; i++)
        if (match[i]) line_q[i] <= line;
    end
  end
endmodule

// File: rtl/l2_evict_buffer.sv
// Write-back eviction buffer between L2 and physical memory.
// FSM and muxes only; storage lives in l2_evict_array.
module l2_evict_buffer #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = lc3b_types::C_ADDR_W,
  parameter int LINE_W = lc3b_types::C_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              l2_read,
  input  logic              l2_write,
  input  logic [ADDR_W-1:0] l2_address,
  input  logic [LINE_W-1:0] l2_wdata,
  output logic              l2_resp,
  output logic [LINE_W-1:0] l2_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  import lc3b_types::*;

  localparam int PW = $clog2(DEPTH);

  lc3b_evict_state state, next;

  logic              push, pop, coal;
  logic [DEPTH-1:0]  match;
  logic [LINE_W-1:0] match_line, head_line;
  logic [ADDR_W-5:0] head_tag;
  logic [PW-1:0]     head_idx;
  logic [PW:0]       count;
  logic              full, hit, head_hit;

  l2_evict_array #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W)
  ) u_arr (
    .clk       (clk),
    .rst       (rst),
    .tag       (l2_address[ADDR_W-1:4]),
    .line      (l2_wdata),
    .push      (push),
    .pop       (pop),
    .coal      (coal),
    .match     (match),
    .match_line(match_line),
    .head_tag  (head_tag),
    .head_line (head_line),
    .head_idx  (head_idx),
    .count     (count),
    .full      (full)
  );

  assign hit      = |match;
  assign head_hit = match[head_idx];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // Next state, handshakes and buffer control.
  always_comb begin
    next         = state;
    l2_resp      = 1'b0;
    l2_rdata     = match_line;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = l2_address;
    pmem_wdata   = head_line;
    push         = 1'b0;
    pop          = 1'b0;
    coal         = 1'b0;
    unique case (state)
      IDLE: begin
        if (l2_write) begin
          if (hit) begin
            coal    = 1'b1;
            l2_resp = 1'b1;
          end else if (!full) begin
            push    = 1'b1;
            l2_resp = 1'b1;
          end else begin
            next = DRAIN;
          end
        end else if (l2_read) begin
          if (hit) l2_resp = 1'b1;
          else     next    = RD_MEM;
        end else if (count != '0) begin
          next = DRAIN;
        end
      end
      RD_MEM: begin
        pmem_read = 1'b1;
        l2_rdata  = pmem_rdata;
        if (pmem_resp) begin
          l2_resp = 1'b1;
          next    = IDLE;
        end
      end
      DRAIN: begin
        pmem_write   = 1'b1;
        pmem_address = {head_tag, 4'b0000};
        if (pmem_resp) begin
          pop  = 1'b1;
          next = IDLE;
        end
        // Head is in flight to pmem: never coalesce into it.
        if (l2_write) begin
          if (hit && !head_hit) begin
            coal    = 1'b1;
            l2_resp = 1'b1;
          end else if (!hit && !full) begin
            push    = 1'b1;
            l2_resp = 1'b1;
          end
        end else if (l2_read && hit) begin
          l2_resp = 1'b1;
        end
      end
      default: next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_l2_evict_buffer.sv
// Directed bench for l2_evict_buffer.
// Hand-driven pmem; inputs change 1ns after posedge.
module tb_l2_evict_buffer;
  logic         clk = 1'b0;
  logic         rst;
  logic         l2_read, l2_write;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic         l2_resp;
  logic [127:0] l2_rdata;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int checks = 0;
  int fails  = 0;

  localparam logic [127:0] D0 = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] D1 = 128'hA1A1_0001;
  localparam logic [127:0] D2 = 128'hA2A2_0002;
  localparam logic [127:0] D3 = 128'hA3A3_0003;
  localparam logic [127:0] D4 = 128'hB4B4_0004;
  localparam logic [127:0] D5 = 128'hB5B5_0005;
  localparam logic [127:0] D6 = 128'hC6C6_0006;
  localparam logic [127:0] D7 = 128'hD7D7_0007;
  localparam logic [127:0] D8 = 128'hE8E8_0008;
  localparam logic [127:0] D9 = 128'hF9F9_0009;

  l2_evict_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .l2_read     (l2_read),
    .l2_write    (l2_write),
    .l2_address  (l2_address),
    .l2_wdata    (l2_wdata),
    .l2_resp     (l2_resp),
    .l2_rdata    (l2_rdata),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_rdata  (pmem_rdata),
    .pmem_resp   (pmem_resp)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    assert (!(l2_read && l2_write));

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [127:0] d);
    l2_write   = 1'b1;
    l2_read    = 1'b0;
    l2_address = a;
    l2_wdata   = d;
    #1;
  endtask

  task automatic rd(input logic [15:0] a);
    l2_read    = 1'b1;
    l2_write   = 1'b0;
    l2_address = a;
    #1;
  endtask

  task automatic idle();
    l2_read  = 1'b0;
    l2_write = 1'b0;
  endtask

  task automatic wait_pwrite(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (pmem_write) break;
      tick();
    end
    chk(tag, 128'(pmem_write), 128'(1));
  endtask

  task automatic drain_one(input string tag, input logic [15:0] a,
                           input logic [127:0] d, input int dly);
    wait_pwrite(tag);
    chk({tag, "_addr"}, 128'(pmem_address), 128'(a));
    chk({tag, "_data"}, pmem_wdata, d);
    repeat (dly) tick();
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    l2_address = '0;
    l2_wdata   = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
    tick();
    tick();
    chk("rst_resp", 128'(l2_resp), 128'(0));
    chk("rst_pwr", 128'(pmem_write), 128'(0));
    chk("rst_prd", 128'(pmem_read), 128'(0));
    chk("rst_cnt", 128'(dut.u_arr.count), 128'(0));
    rst = 1'b0;

    // 1: buffered write, background drain
    wr(16'h1230, D0);
    chk("t1_resp", 128'(l2_resp), 128'(1));
    tick();
    idle();
    #1;
    chk("t1_gap", 128'(pmem_write), 128'(0));
    tick();
    chk("t1_pwr", 128'(pmem_write), 128'(1));
    chk("t1_addr", 128'(pmem_address), 128'(16'h1230));
    chk("t1_data", pmem_wdata, D0);
    repeat (4) tick();
    chk("t1_hold", 128'(pmem_write), 128'(1));
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    #1;
    chk("t1_cnt", 128'(dut.u_arr.count), 128'(0));
    chk("t1_done", 128'(pmem_write), 128'(0));

    // 2: read hit on an undrained line
    wr(16'h1230, D0);
    chk("t2_wresp", 128'(l2_resp), 128'(1));
    tick();
    rd(16'h1238);
    chk("t2_rresp", 128'(l2_resp), 128'(1));
    chk("t2_rdata", l2_rdata, D0);
    chk("t2_prd", 128'(pmem_read), 128'(0));
    tick();
    idle();
    drain_one("t2_drain", 16'h1230, D0, 1);

    // 3: full buffer stalls third write
    #1;
    wr(16'h1000, D1);
    chk("t3_r1", 128'(l2_resp), 128'(1));
    tick();
    wr(16'h2000, D2);
    chk("t3_r2", 128'(l2_resp), 128'(1));
    tick();
    wr(16'h3000, D3);
    chk("t3_r3_stall", 128'(l2_resp), 128'(0));
    tick();
    chk("t3_pwr", 128'(pmem_write), 128'(1));
    chk("t3_addr", 128'(pmem_address), 128'(16'h1000));
    chk("t3_data", pmem_wdata, D1);
    chk("t3_stall2", 128'(l2_resp), 128'(0));
    tick();
    pmem_resp = 1'b1;
    #1;
    chk("t3_stall3", 128'(l2_resp), 128'(0));
    tick();
    pmem_resp = 1'b0;
    #1;
    chk("t3_tail", 128'(dut.u_arr.tail), 128'(0));
    chk("t3_r3", 128'(l2_resp), 128'(1));
    tick();
    idle();
    drain_one("t3_d2", 16'h2000, D2, 0);
    drain_one("t3_d3", 16'h3000, D3, 2);

    // 4: coalescing
    #1;
    wr(16'h4000, D4);
    chk("t4_r1", 128'(l2_resp), 128'(1));
    tick();
    wr(16'h4000, D5);
    chk("t4_r2", 128'(l2_resp), 128'(1));
    tick();
    idle();
    #1;
    chk("t4_cnt", 128'(dut.u_arr.count), 128'(1));
    drain_one("t4_drain", 16'h4000, D5, 1);
    #1;
    chk("t4_cnt0", 128'(dut.u_arr.count), 128'(0));

    // 5: read miss during drain
    wr(16'h1000, D6);
    tick();
    idle();
    wait_pwrite("t5_pwr");
    rd(16'h5000);
    chk("t5_wait", 128'(l2_resp), 128'(0));
    chk("t5_noprd", 128'(pmem_read), 128'(0));
    tick();
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    #1;
    chk("t5_wdone", 128'(pmem_write), 128'(0));
    tick();
    chk("t5_prd", 128'(pmem_read), 128'(1));
    chk("t5_paddr", 128'(pmem_address), 128'(16'h5000));
    tick();
    pmem_rdata = D7;
    pmem_resp  = 1'b1;
    #1;
    chk("t5_resp", 128'(l2_resp), 128'(1));
    chk("t5_rdata", l2_rdata, D7);
    tick();
    pmem_resp = 1'b0;
    idle();
    #1;
    chk("t5_prd0", 128'(pmem_read), 128'(0));

    // 6: reset mid-drain
    wr(16'h1000, D8);
    tick();
    idle();
    wait_pwrite("t6_pwr");
    rst = 1'b1;
    tick();
    chk("t6_pwr0", 128'(pmem_write), 128'(0));
    chk("t6_cnt", 128'(dut.u_arr.count), 128'(0));
    rst = 1'b0;
    rd(16'h1000);
    chk("t6_miss", 128'(l2_resp), 128'(0));
    tick();
    chk("t6_prd", 128'(pmem_read), 128'(1));
    chk("t6_paddr", 128'(pmem_address), 128'(16'h1000));
    pmem_rdata = D9;
    pmem_resp  = 1'b1;
    #1;
    chk("t6_resp", 128'(l2_resp), 128'(1));
    chk("t6_rdata", l2_rdata, D9);
    tick();
    pmem_resp = 1'b0;
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
